// File: rtl/edge_detect_multi.sv
// -----------------------------------------------------------------------------
// edge_detect_multi
//
// Multi-channel edge detector for asynchronous pins or buttons. Each channel:
//   raw input -> flop synchroniser -> stability filter -> filtered level,
//   one-cycle rise/fall pulses and a maskable sticky pending flag.
// The pending flags are OR-reduced into a single interrupt.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   sig_in     [CH] raw asynchronous inputs, bit i = channel i
//   pos_en     [CH] a filtered rising edge sets pend[i]
//   neg_en     [CH] a filtered falling edge sets pend[i]
//   clr        [CH] write-1-to-clear for pend, sampled every cycle
//   level_out  [CH] filtered, synchronised level
//   pos_edge   [CH] one-cycle pulse on filtered 0->1 (not masked)
//   neg_edge   [CH] one-cycle pulse on filtered 1->0 (not masked)
//   pend       [CH] sticky pending flags
//   irq        OR of pend
// -----------------------------------------------------------------------------
module edge_detect_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] sig_in,
    input  logic [CH-1:0] pos_en,
    input  logic [CH-1:0] neg_en,
    input  logic [CH-1:0] clr,
    output logic [CH-1:0] level_out,
    output logic [CH-1:0] pos_edge,
    output logic [CH-1:0] neg_edge,
    output logic [CH-1:0] pend,
    output logic          irq
);

    // The counter only needs to reach FILT_CYC-1; keep at least one bit so
    // FILT_CYC=1 (no filtering) still elaborates cleanly.
    localparam int              CNT_W    = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic                   lvl_reg;
            logic                   pos_reg;
            logic                   neg_reg;
            logic                   pend_reg;
            logic                   sync_val;
            logic                   differ;
            logic                   qualified;
            logic                   rise;
            logic                   fall;

            assign sync_val  = sync_reg[SYNC_STAGES-1];
            assign differ    = (sync_val != lvl_reg);
            // The new value has now been seen on FILT_CYC consecutive edges.
            assign qualified = differ && (cnt_reg == CNT_LAST);
            assign rise      = qualified && sync_val;
            assign fall      = qualified && !sync_val;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg <= '0;
                    cnt_reg  <= '0;
                    lvl_reg  <= 1'b0;
                    pos_reg  <= 1'b0;
                    neg_reg  <= 1'b0;
                    pend_reg <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in[gi]};

                    // Any return to the current level restarts qualification,
                    // so excursions shorter than FILT_CYC are discarded.
                    if (!differ) begin
                        cnt_reg <= '0;
                    end else if (qualified) begin
                        lvl_reg <= sync_val;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end

                    pos_reg <= rise;
                    neg_reg <= fall;

                    // A set on the same edge as a clear wins.
                    pend_reg <= (pend_reg & ~clr[gi])
                              | (pos_en[gi] & rise)
                              | (neg_en[gi] & fall);
                end
            end

            assign level_out[gi] = lvl_reg;
            assign pos_edge[gi]  = pos_reg;
            assign neg_edge[gi]  = neg_reg;
            assign pend[gi]      = pend_reg;
        end
    endgenerate

    // Driven purely from flops, so the interrupt line cannot glitch on
    // input activity.
    assign irq = |pend;

endmodule

// File: tb/tb_edge_detect_multi.sv
// -----------------------------------------------------------------------------
// tb_edge_detect_multi
//
// Self-checking bench for edge_detect_multi (CH=4, SYNC_STAGES=2, FILT_CYC=3).
// The reference model states the filter as a window rule: the filtered level
// takes value v on an edge when the synchronised samples seen on the last
// FILT_CYC edges all equal v; otherwise it holds. Pulses are the level
// changes, pending follows the set/clear rule with set taking priority.
// -----------------------------------------------------------------------------
module tb_edge_detect_multi;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int FILT = 3;
    localparam int HL   = SYNC + FILT - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] sig_in;
    logic [CH-1:0] pos_en;
    logic [CH-1:0] neg_en;
    logic [CH-1:0] clr;
    logic [CH-1:0] level_out;
    logic [CH-1:0] pos_edge;
    logic [CH-1:0] neg_edge;
    logic [CH-1:0] pend;
    logic          irq;

    int total = 0;
    int bad   = 0;

    edge_detect_multi #(
        .CH          (CH),
        .SYNC_STAGES (SYNC),
        .FILT_CYC    (FILT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .pos_en    (pos_en),
        .neg_en    (neg_en),
        .clr       (clr),
        .level_out (level_out),
        .pos_edge  (pos_edge),
        .neg_edge  (neg_edge),
        .pend      (pend),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist[k] holds the raw input sampled k+1 edges ago (before the current
    // edge). The synchronised value seen at an edge is the raw sample taken
    // SYNC edges earlier, so the last FILT synchronised samples are
    // hist[SYNC-1 .. HL-1].
    logic [CH-1:0] hist [0:HL-1];
    logic [CH-1:0] m_lvl, m_pos, m_neg, m_pend;
    logic [CH-1:0] win_and, win_or, m_new;

    always_comb begin
        win_and = '1;
        win_or  = '0;
        for (int k = SYNC - 1; k < HL; k++) begin
            win_and = win_and & hist[k];
            win_or  = win_or | hist[k];
        end
        m_new = win_and | (m_lvl & win_or);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < HL; k++) hist[k] <= '0;
            m_lvl  <= '0;
            m_pos  <= '0;
            m_neg  <= '0;
            m_pend <= '0;
        end else begin
            hist[0] <= sig_in;
            for (int k = 1; k < HL; k++) hist[k] <= hist[k-1];
            m_lvl  <= m_new;
            m_pos  <= m_new & ~m_lvl;
            m_neg  <= ~m_new & m_lvl;
            m_pend <= (m_pend & ~clr) | (pos_en & m_new & ~m_lvl)
                    | (neg_en & ~m_new & m_lvl);
        end
    end

    logic [4*CH:0] obs_vec, exp_vec;
    assign obs_vec = {level_out, pos_edge, neg_edge, pend, irq};
    assign exp_vec = {m_lvl, m_pos, m_neg, m_pend, |m_pend};

    // Advance one clock; returns at the falling edge, where outputs are
    // sampled and new inputs applied.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; sig_in = 4'hF; pos_en = 4'hF; neg_en = 4'hF; clr = 4'h0;
        @(negedge clk);
        tick();
        $display("reset: held with sig_in=%h", sig_in);
        total++;
        if (obs_vec !== '0) begin
            bad++; $display("FAIL reset_hold got=%h exp=0", obs_vec);
        end
        rst = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            total++;
            if (pos_edge !== ((c == 5) ? 4'hF : 4'h0)) begin
                bad++; $display("FAIL reset_pos_edge edge=%0d got=%h exp=%h", c, pos_edge,
                                (c == 5) ? 4'hF : 4'h0);
            end
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL reset_model edge=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
        end
        total++;
        if ({level_out, pend, irq} !== {4'hF, 4'hF, 1'b1}) begin
            bad++; $display("FAIL reset_after lvl/pend/irq got=%h/%h/%b exp=f/f/1",
                            level_out, pend, irq);
        end
    endtask

    task automatic test_filter();
        sig_in = 4'h0;
        for (int c = 0; c < 8; c++) tick();
        clr = 4'hF; tick(); clr = 4'h0;
        sig_in[0] = 1'b1;
        $display("filter: ch0 rise");
        for (int c = 1; c <= 8; c++) begin
            tick();
            total++;
            if (pos_edge[0] !== (c == 5)) begin
                bad++; $display("FAIL filter_rise edge=%0d got=%b exp=%b", c, pos_edge[0], c == 5);
            end
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL filter_model edge=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
        end
        $display("filter: ch0 2-cycle low glitch");
        sig_in[0] = 1'b0; tick(); tick(); sig_in[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            total++;
            if (neg_edge[0] !== 1'b0 || level_out[0] !== 1'b1) begin
                bad++; $display("FAIL filter_glitch edge=%0d neg=%b lvl=%b exp neg=0 lvl=1",
                                c, neg_edge[0], level_out[0]);
            end
        end
        $display("filter: ch0 3-cycle low");
        begin
            int npulse = 0;
            sig_in[0] = 1'b0; tick(); tick(); tick(); sig_in[0] = 1'b1;
            npulse += int'(neg_edge[0]);
            for (int c = 1; c <= 12; c++) begin
                tick();
                npulse += int'(neg_edge[0]);
                total++;
                if (obs_vec !== exp_vec) begin
                    bad++; $display("FAIL filter_low_model edge=%0d got=%h exp=%h", c, obs_vec, exp_vec);
                end
            end
            total++;
            if (npulse != 1) begin
                bad++; $display("FAIL filter_low_pulses got=%0d exp=1", npulse);
            end
        end
    endtask

    task automatic test_masking();
        sig_in = 4'h0;
        for (int c = 0; c < 8; c++) tick();
        clr = 4'hF; tick(); clr = 4'h0;
        pos_en = 4'b0001; neg_en = 4'b0000;
        sig_in = 4'b0011;
        $display("masking: ch0+ch1 rise, pos_en=0001");
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 5) begin
                total++;
                if (pos_edge !== 4'b0011 || pend !== 4'b0001) begin
                    bad++; $display("FAIL mask_rise pos=%b pend=%b exp pos=0011 pend=0001", pos_edge, pend);
                end
            end
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL mask_model edge=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
        end
        sig_in = 4'b0010;
        $display("masking: ch0 fall, neg_en=0");
        for (int c = 1; c <= 8; c++) begin
            tick();
            total++;
            if (neg_edge !== ((c == 5) ? 4'b0001 : 4'b0000) || pend !== 4'b0001) begin
                bad++; $display("FAIL mask_fall edge=%0d neg=%b pend=%b exp neg=%b pend=0001",
                                c, neg_edge, pend, (c == 5) ? 4'b0001 : 4'b0000);
            end
        end
        pos_en = 4'hF; neg_en = 4'hF;
    endtask

    task automatic test_clear_race();
        clr = 4'hF; tick(); clr = 4'h0;
        sig_in[2] = 1'b1;
        $display("clear: ch2 rise then clr[2]");
        for (int c = 0; c < 6; c++) tick();
        total++;
        if (pend !== 4'b0100 || irq !== 1'b1) begin
            bad++; $display("FAIL clear_set pend=%b irq=%b exp pend=0100 irq=1", pend, irq);
        end
        clr = 4'b0100; tick(); clr = 4'h0;
        total++;
        if (pend !== 4'b0000 || irq !== 1'b0) begin
            bad++; $display("FAIL clear_w1c pend=%b irq=%b exp pend=0000 irq=0", pend, irq);
        end
        $display("clear: clr[2] on the edge a ch2 fall registers");
        sig_in[2] = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        clr = 4'b0100; tick(); clr = 4'h0;
        total++;
        if (pend[2] !== 1'b1 || neg_edge[2] !== 1'b1) begin
            bad++; $display("FAIL clear_race pend2=%b neg2=%b exp 1/1", pend[2], neg_edge[2]);
        end
        total++;
        if (obs_vec !== exp_vec) begin
            bad++; $display("FAIL clear_model got=%h exp=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_reset_mid();
        clr = 4'hF; tick(); clr = 4'h0;
        sig_in[3] = 1'b1;
        $display("reset_mid: ch3 rise, reset at counter 2");
        for (int c = 0; c < 4; c++) tick();
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs_vec !== '0) begin
            bad++; $display("FAIL reset_mid_async got=%h exp=0", obs_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            total++;
            if (pos_edge !== ((c == 5) ? sig_in : 4'h0)) begin
                bad++; $display("FAIL reset_mid_pos edge=%0d got=%b exp=%b", c, pos_edge,
                                (c == 5) ? sig_in : 4'h0);
            end
        end
    endtask

    task automatic test_independence();
        int per [CH];
        int tog [CH];
        int pul [CH];
        per[0] = 8; per[1] = 12; per[2] = 16; per[3] = 20;
        sig_in = 4'h0;
        for (int c = 0; c < 8; c++) tick();
        for (int i = 0; i < CH; i++) begin tog[i] = 0; pul[i] = 0; end
        $display("independence: periods 8/12/16/20");
        for (int n = 1; n <= 250; n++) begin
            if (n <= 240) begin
                for (int i = 0; i < CH; i++) begin
                    if (n % per[i] == 0) begin
                        sig_in[i] = ~sig_in[i];
                        tog[i]++;
                    end
                end
            end
            tick();
            for (int i = 0; i < CH; i++) pul[i] += int'(pos_edge[i]) + int'(neg_edge[i]);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL indep_model n=%0d got=%h exp=%h", n, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < CH; i++) begin
            total++;
            if (pul[i] != tog[i]) begin
                bad++; $display("FAIL indep_pulses ch=%0d got=%0d exp=%0d", i, pul[i], tog[i]);
            end
        end
    endtask

    task automatic test_random();
        $display("random: 400 cycles of random inputs, enables and clears");
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 4) == 0) sig_in[i] = ~sig_in[i];
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            if (n % 50 == 0) begin
                pos_en = 4'($urandom);
                neg_en = 4'($urandom);
            end
            tick();
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL random_model n=%0d got=%h exp=%h", n, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_filter();
        test_masking();
        test_clear_race();
        test_reset_mid();
        test_independence();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
